dbus_store_buffer: RTL and testbench

//  Posted-write buffer between the core LSU data-bus master and the data memory/interconnect.

---
 rtl/dbus_store_buffer_pkg.sv | 33 +++
 rtl/dbus_store_buffer_if.sv | 18 +
 rtl/dbus_store_buffer_fifo.sv | 100 ++++++++++
 rtl/dbus_store_buffer.sv | 115 +++++++++++
 tb/tb_dbus_store_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_store_buffer_pkg
//  Description : Shared types for the LSU data-bus store buffer: Avalon-style
//                request/response bundles, the buffered store entry and the
//                default buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbus_store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dbus_store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_store_buffer_if
//  Description : Avalon-style data-bus link (request out, response back).
//                master drives req, slave drives resp.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dbus_store_buffer_if;
  import dbus_store_buffer_pkg::*;

  avalon_req_t  req;
  avalon_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface
`default_nettype wire

// File: rtl/dbus_store_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_store_buffer_fifo
//  Description : Circular entry store for the store buffer. Holds pointers,
//                occupancy and per-entry valid bits, exposes the head entry
//                and, when STORE_BUFFER_RD_BYPASS_EN is defined, a per-entry
//                word-address match vector against a load address.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_store_buffer_fifo
  import dbus_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sb_entry_t              push_entry,
  input  logic                   pop,
  output sb_entry_t              head,
  output logic                   full,
  output logic                   empty,
`ifdef STORE_BUFFER_RD_BYPASS_EN
  input  logic [29:0]            cmp_word,
  output logic [DEPTH-1:0]       match,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = entry_q[rd_ptr_q];
  // A full buffer refuses a push even when the head retires the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Retire the head, append at the tail, pointers wrap at DEPTH (power of 2)
  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      entry_d[wr_ptr_q] = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: valid bits qualify it
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

`ifdef STORE_BUFFER_RD_BYPASS_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = valid_q[i] & (entry_q[i].address[31:2] == cmp_word);
  end
`endif

endmodule
`default_nettype wire

// File: rtl/dbus_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_store_buffer
//  Description : Posted-write buffer between the LSU data-bus master and data
//                memory. Stores are accepted with no wait cycles while not
//                full and drained in order; loads go straight to memory once
//                ordering against pending stores allows.
//                Build option STORE_BUFFER_RD_BYPASS_EN: loads to words with
//                no pending store overtake the buffer; otherwise loads wait
//                for the buffer to empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_store_buffer
  import dbus_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  dbus_store_buffer_if.slave     up,
  dbus_store_buffer_if.master    dn,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
);

  sb_entry_t    push_entry;
  sb_entry_t    head;
  logic         full;
  logic         empty;
  logic         pop;
  logic         rd_allowed;
  logic         rd_fwd;
  logic         drain;
  logic         wr_lock_q, wr_lock_d;
  avalon_req_t  dn_req;
  avalon_resp_t up_resp;
`ifdef STORE_BUFFER_RD_BYPASS_EN
  logic [DEPTH-1:0] match;
`endif

  assign push_entry = '{address:     up.req.address,
                        writedata:   up.req.writedata,
                        byte_enable: up.req.byte_enable};

  dbus_store_buffer_fifo #(
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (up.req.write),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
`ifdef STORE_BUFFER_RD_BYPASS_EN
    .cmp_word   (up.req.address[31:2]),
    .match      (match),
`endif
    .count      (sb_count)
  );

  // A stalled drain write owns the bus until memory takes it (wr_lock_q).
`ifdef STORE_BUFFER_RD_BYPASS_EN
  assign rd_allowed = ~wr_lock_q & ~(|match);
`else
  assign rd_allowed = ~wr_lock_q & empty;
`endif

  assign rd_fwd   = up.req.read & rd_allowed;
  assign drain    = ~rd_fwd & ~empty;
  assign pop      = drain & ~dn.resp.waitrequest;
  assign sb_empty = empty;

  // Arbitrate the downstream port (forwarded load vs head drain) and answer the LSU
  always_comb begin
    dn_req              = '0;
    up_resp.readdata    = dn.resp.readdata;
    up_resp.waitrequest = 1'b0;
    wr_lock_d           = drain & dn.resp.waitrequest;
    if (rd_fwd) begin
      dn_req.read        = 1'b1;
      dn_req.address     = up.req.address;
      dn_req.byte_enable = up.req.byte_enable;
    end else if (drain) begin
      dn_req.write       = 1'b1;
      dn_req.address     = head.address;
      dn_req.writedata   = head.writedata;
      dn_req.byte_enable = head.byte_enable;
    end
    if (up.req.read) begin
      up_resp.waitrequest = rd_fwd ? dn.resp.waitrequest : 1'b1;
    end else if (up.req.write) begin
      up_resp.waitrequest = full;
    end
  end

  // Remember a drain write left pending by memory; reset drops it
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_lock_q <= 1'b0;
    end else begin
      wr_lock_q <= wr_lock_d;
    end
  end

  assign dn.req  = dn_req;
  assign up.resp = up_resp;

  // The LSU never issues a load and a store in the same cycle
  a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(up.req.read && up.req.write));

endmodule
`default_nettype wire

// File: tb/tb_dbus_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_store_buffer
//  Description : Self-checking bench for dbus_store_buffer: a vector table,
//                directed multi-cycle sequences and a random LSU traffic run
//                against a program-order memory model and store scoreboard.
//                Honours STORE_BUFFER_RD_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_store_buffer;
  import dbus_store_buffer_pkg::*;

  localparam int DEPTH = SB_DEPTH_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbus_store_buffer_if up_if ();
  dbus_store_buffer_if dn_if ();

  logic                   sb_empty;
  logic [$clog2(DEPTH):0] sb_count;
  avalon_req_t            lsu_req;
  logic                   dn_wait;
  logic [31:0]            rdata_q;
  logic [31:0]            rdata_next;

  assign up_if.req  = lsu_req;
  assign dn_if.resp = '{readdata: rdata_q, waitrequest: dn_wait};

  dbus_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (up_if.slave),
    .dn       (dn_if.master),
    .sb_empty (sb_empty),
    .sb_count (sb_count)
  );

  // Model: memory contents, program-order view and stores not yet written.
  logic [31:0] mem    [int unsigned];
  logic [31:0] refmem [int unsigned];
  sb_entry_t   exp_q  [$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          rd_chk_pend;
  logic [31:0] rd_chk_exp;
  int          rd_wait_cycles;
  bit          last_accept;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_wait;
    int          exp_count;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned k);
    return refmem.exists(k) ? refmem[k] : 32'h0;
  endfunction

  // Observe one cycle mid-period: memory response, scoreboard and load rules.
  task automatic monitor();
    int          sz;
    bit          hazard;
    int unsigned k;
    last_accept = 1'b0;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      refmem      = mem;
      rd_chk_pend = 1'b0;
      return;
    end
    chk("sb_count", 32'(sb_count), sz);
    chk("sb_empty", 32'(sb_empty), 32'(sz == 0));
    if (rd_chk_pend) begin
      chk("load_data", up_if.resp.readdata, rd_chk_exp);
      rd_chk_pend = 1'b0;
    end
    chk("dn_rd_wr_exclusive", 32'(dn_if.req.read & dn_if.req.write), 0);
    if (sz == 0) begin
      chk("dn_write_when_empty", 32'(dn_if.req.write), 0);
    end else begin
      if (!lsu_req.read) chk("drain_active", 32'(dn_if.req.write), 1);
      if (dn_if.req.write) begin
        chk("dn_wr_addr", dn_if.req.address, exp_q[0].address);
        chk("dn_wr_data", dn_if.req.writedata, exp_q[0].writedata);
        chk("dn_wr_be", 32'(dn_if.req.byte_enable), 32'(exp_q[0].byte_enable));
      end
    end
    hazard = 1'b0;
`ifdef STORE_BUFFER_RD_BYPASS_EN
    foreach (exp_q[j]) if (exp_q[j].address[31:2] == lsu_req.address[31:2]) hazard = 1'b1;
`else
    hazard = (sz != 0);
`endif
    if (dn_if.req.write && !dn_wait && sz != 0) begin
      k = int'(exp_q[0].address[31:2]);
      mem[k] = merge(mem_rd(k), exp_q[0].writedata, exp_q[0].byte_enable);
      void'(exp_q.pop_front());
    end
    if (dn_if.req.read && !dn_wait) rdata_next = mem_rd(int'(dn_if.req.address[31:2]));
    if (dn_if.req.read) chk("rd_waitreq_passthru", 32'(up_if.resp.waitrequest), 32'(dn_wait));
    if (lsu_req.write) begin
      chk("st_waitreq", 32'(up_if.resp.waitrequest), 32'(sz >= DEPTH));
      if (sz < DEPTH) begin
        exp_q.push_back('{address: lsu_req.address, writedata: lsu_req.writedata,
                          byte_enable: lsu_req.byte_enable});
        k = int'(lsu_req.address[31:2]);
        refmem[k] = merge(ref_rd(k), lsu_req.writedata, lsu_req.byte_enable);
        last_accept = 1'b1;
      end
    end else if (lsu_req.read) begin
      if (!up_if.resp.waitrequest) begin
        chk("ld_fwd_read", 32'(dn_if.req.read), 1);
        chk("ld_fwd_addr", dn_if.req.address, lsu_req.address);
        chk("ld_fwd_be", 32'(dn_if.req.byte_enable), 32'(lsu_req.byte_enable));
        chk("ld_order", 32'(hazard), 0);
        rd_chk_pend    = 1'b1;
        rd_chk_exp     = ref_rd(int'(lsu_req.address[31:2]));
        rd_wait_cycles = 0;
        last_accept    = 1'b1;
      end else begin
        rd_wait_cycles++;
        if (rd_wait_cycles > 64) begin
          chk("ld_timeout", 32'(rd_wait_cycles), 64);
          rd_wait_cycles = 0;
        end
      end
    end else begin
      chk("idle_waitreq", 32'(up_if.resp.waitrequest), 0);
      chk("idle_no_dn_read", 32'(dn_if.req.read), 0);
    end
  endtask

  task automatic cycle();
    #1;
    monitor();
    @(posedge clk);
    #1;
    rdata_q = rdata_next;
  endtask

  function automatic avalon_req_t mk_st(input logic [31:0] a, input logic [31:0] d);
    return '{read: 1'b0, write: 1'b1, address: a, writedata: d, byte_enable: 4'hF};
  endfunction

  function automatic avalon_req_t mk_ld(input logic [31:0] a);
    return '{read: 1'b1, write: 1'b0, address: a, writedata: 32'h0, byte_enable: 4'hF};
  endfunction

  logic [31:0] t2_addr [5];

  initial begin
    lsu_req = '0; dn_wait = 1'b0; rdata_q = '0; rdata_next = '0;
    rd_chk_pend = 1'b0; rd_chk_exp = '0; rd_wait_cycles = 0; last_accept = 1'b0;
    vecs[0] = '{32'h100, 32'hA000_0100, 1'b0, 1};
    vecs[1] = '{32'h104, 32'hA000_0104, 1'b0, 2};
    vecs[2] = '{32'h108, 32'hA000_0108, 1'b0, 3};
    vecs[3] = '{32'h10C, 32'hA000_010C, 1'b0, 4};
    vecs[4] = '{32'h110, 32'hA000_0110, 1'b1, 4};
    t2_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};

    // Reset state
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(sb_count), 0);
    chk("rst_empty", 32'(sb_empty), 1);
    chk("rst_dn_write", 32'(dn_if.req.write), 0);
    chk("rst_dn_read", 32'(dn_if.req.read), 0);
    chk("rst_up_wait", 32'(up_if.resp.waitrequest), 0);

    // Fill with memory stalled; the fifth store must be refused
    dn_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lsu_req = mk_st(vecs[i].addr, vecs[i].data);
      #1;
      chk("t1_up_wait", 32'(up_if.resp.waitrequest), 32'(vecs[i].exp_wait));
      cycle();
      chk("t1_count", 32'(sb_count), vecs[i].exp_count);
    end

    // Release memory: five in-order drain writes, one per cycle
    dn_wait = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_dn_write", 32'(dn_if.req.write), 1);
      chk("t2_dn_addr", dn_if.req.address, t2_addr[i]);
      if (i < 2) chk("t2_up_wait", 32'(up_if.resp.waitrequest), 32'(i == 0));
      cycle();
      if (i == 1) lsu_req = '0;
    end
    chk("t2_empty", 32'(sb_empty), 1);

    // Load behind a store to the same word waits for the store to retire
    dn_wait = 1'b1;
    lsu_req = mk_st(32'h200, 32'hDEAD_BEEF);
    cycle();
    lsu_req = mk_ld(32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_blocked", 32'(up_if.resp.waitrequest), 1);
      chk("t3_no_dn_read", 32'(dn_if.req.read), 0);
      cycle();
    end
    dn_wait = 1'b0;
    #1;
    chk("t3_blocked_at_pop", 32'(up_if.resp.waitrequest), 1);
    chk("t3_write_held", 32'(dn_if.req.write), 1);
    cycle();
    #1;
    chk("t3_dn_read", 32'(dn_if.req.read), 1);
    chk("t3_up_wait", 32'(up_if.resp.waitrequest), 0);
    cycle();
    lsu_req = '0;
    #1;
    chk("t3_readdata", up_if.resp.readdata, 32'hDEAD_BEEF);

    // Load to another word while a store is pending
    lsu_req = mk_st(32'h300, 32'h1234_5678);
    cycle();
    lsu_req = '0;
    cycle(); cycle(); cycle();
    lsu_req = mk_st(32'h200, 32'h0000_0055);
    cycle();
    lsu_req = mk_ld(32'h300);
`ifdef STORE_BUFFER_RD_BYPASS_EN
    #1;
    chk("t4_dn_read", 32'(dn_if.req.read), 1);
    chk("t4_no_drain", 32'(dn_if.req.write), 0);
    chk("t4_up_wait", 32'(up_if.resp.waitrequest), 0);
    cycle();
    lsu_req = '0;
    #1;
    chk("t4_count", 32'(sb_count), 1);
    chk("t4_readdata", up_if.resp.readdata, 32'h1234_5678);
`else
    #1;
    chk("t5_stall", 32'(up_if.resp.waitrequest), 1);
    chk("t5_no_dn_read", 32'(dn_if.req.read), 0);
    chk("t5_drain", 32'(dn_if.req.write), 1);
    cycle();
    #1;
    chk("t5_empty", 32'(sb_empty), 1);
    chk("t5_dn_read", 32'(dn_if.req.read), 1);
    chk("t5_up_wait", 32'(up_if.resp.waitrequest), 0);
    cycle();
    lsu_req = '0;
    #1;
    chk("t5_readdata", up_if.resp.readdata, 32'h1234_5678);
`endif
    cycle(); cycle(); cycle();

    // Reset while three stores are buffered and the head write is stalled
    dn_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lsu_req = mk_st(32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      cycle();
    end
    lsu_req = '0;
    #1;
    chk("t6_in_flight", 32'(dn_if.req.write), 1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("t6_dn_write", 32'(dn_if.req.write), 0);
    chk("t6_count", 32'(sb_count), 0);
    chk("t6_empty", 32'(sb_empty), 1);
    dn_wait = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_no_write", 32'(dn_if.req.write), 0);
      cycle();
    end

    // Random LSU traffic; a refused request is held until accepted
    last_accept = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (last_accept || (!lsu_req.read && !lsu_req.write)) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) begin
          lsu_req = '{read: 1'b0, write: 1'b1,
                      address: 32'h800 + {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                      writedata: $urandom, byte_enable: 4'($urandom_range(1, 15))};
        end else if (r < 7) begin
          lsu_req = mk_ld(32'h800 + {26'h0, 4'($urandom_range(0, 15)), 2'b00});
        end else begin
          lsu_req = '0;
        end
      end
      dn_wait = ($urandom_range(0, 9) < 3);
      cycle();
    end
    lsu_req = '0;
    dn_wait = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("final_empty", 32'(sb_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
